// File: rtl/rotary_pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : rotary_pwm_dimmer
// Description : Multi-channel LED dimmer controlled by a quadrature rotary
//               encoder with push switch. Detents raise/lower the selected
//               channel's level; presses cycle the selected channel. All
//               channels share one free-running PWM counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rotary_pwm_dimmer #(
    parameter int PWM_BITS        = 8,
    parameter int CHANNELS        = 4,
    parameter int STEP            = 1,
    parameter int DEBOUNCE_CYCLES = 10000,
    localparam int c_SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ROT_A,
    input  logic                ROT_B,
    input  logic                ROT_CENTER,
    output logic [CHANNELS-1:0] LED,
    output logic [c_SEL_W-1:0]  SEL,
    output logic [PWM_BITS-1:0] LEVEL,
    output logic                ROT_EVENT
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1
    localparam int                  c_DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_SEL_W-1:0]  c_SEL_LAST  = c_SEL_W'(CHANNELS - 1);
    localparam logic [PWM_BITS-1:0] c_MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   c_MAX_W     = {1'b0, c_MAX};
    localparam logic [PWM_BITS:0]   c_STEP_W    = (PWM_BITS + 1)'(STEP);
    // Counter wraps one short of full scale so full scale means "always on"
    localparam logic [PWM_BITS-1:0] c_PWM_LAST  = c_MAX - 1'b1;

    // Bit 0 = A, bit 1 = B, bit 2 = CENTER
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_deb;

    // Two-flop synchronisers on the raw encoder pins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {ROT_CENTER, ROT_B, ROT_A};
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
            logic [c_DB_W-1:0] r_cnt;
            logic [c_DB_W-1:0] w_cnt_d;
            logic              r_state;
            logic              w_state_d;

            // Accept a new value only after it has been stable long enough
            always_comb begin
                w_cnt_d   = '0;
                w_state_d = r_state;
                if (r_sync2[gi] != r_state) begin
                    if (r_cnt == c_DB_LAST) begin
                        w_state_d = r_sync2[gi];
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end

            // Debounce state register
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_cnt   <= '0;
                    r_state <= 1'b0;
                end else begin
                    r_cnt   <= w_cnt_d;
                    r_state <= w_state_d;
                end
            end

            assign w_deb[gi] = r_state;
        end
    endgenerate

    logic                r_a_prev;
    logic                r_c_prev;
    logic                r_event;
    logic                r_right;
    logic [c_SEL_W-1:0]  r_sel;
    logic [PWM_BITS-1:0] r_level [CHANNELS];
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [CHANNELS-1:0] r_led;

    logic                w_a_rise;
    logic                w_c_rise;
    logic [c_SEL_W-1:0]  w_sel_d;
    logic [PWM_BITS-1:0] w_level_d [CHANNELS];
    logic [PWM_BITS:0]   w_cur;
    logic [PWM_BITS:0]   w_sum;
    logic [PWM_BITS:0]   w_diff;
    logic [PWM_BITS-1:0] w_new;
    logic [PWM_BITS-1:0] w_pwm_d;
    logic [CHANNELS-1:0] w_led_d;

    assign w_a_rise = w_deb[0] & ~r_a_prev;
    assign w_c_rise = w_deb[2] & ~r_c_prev;

    // Saturating level update on the selected channel, selection advance,
    // PWM counter and per-channel compare
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_level_d[i] = r_level[i];
        end
        // One extra bit keeps overflow/borrow visible so the level never wraps
        w_cur  = {1'b0, r_level[r_sel]};
        w_sum  = w_cur + c_STEP_W;
        w_diff = w_cur - c_STEP_W;
        w_new  = r_level[r_sel];
        if (r_event) begin
            if (r_right) begin
                w_new = (w_sum > c_MAX_W) ? c_MAX : w_sum[PWM_BITS-1:0];
            end else begin
                w_new = w_diff[PWM_BITS] ? '0 : w_diff[PWM_BITS-1:0];
            end
            // Uses the pre-press selection even if a press lands this cycle
            w_level_d[r_sel] = w_new;
        end

        w_sel_d = r_sel;
        if (w_c_rise) begin
            w_sel_d = (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
        end

        w_pwm_d = (r_pwm_cnt == c_PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;

        for (int i = 0; i < CHANNELS; i++) begin
            w_led_d[i] = (r_pwm_cnt < r_level[i]);
        end
    end

    // Control, level and PWM state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_prev  <= 1'b0;
            r_c_prev  <= 1'b0;
            r_event   <= 1'b0;
            r_right   <= 1'b0;
            r_sel     <= '0;
            r_pwm_cnt <= '0;
            r_led     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_a_prev  <= w_deb[0];
            r_c_prev  <= w_deb[2];
            r_event   <= w_a_rise;
            // B low at the A rising edge means clockwise (increment)
            r_right   <= ~w_deb[1];
            r_sel     <= w_sel_d;
            r_pwm_cnt <= w_pwm_d;
            r_led     <= w_led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                r_level[i] <= w_level_d[i];
            end
        end
    end

    assign LED       = r_led;
    assign SEL       = r_sel;
    assign LEVEL     = r_level[r_sel];
    assign ROT_EVENT = r_event;

endmodule
`default_nettype wire

// File: tb/tb_rotary_pwm_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotary_pwm_dimmer
// Description : Self-checking bench for rotary_pwm_dimmer. Two instances
//               (STEP=1 and STEP=4) share one encoder input set; a
//               per-channel level model predicts LEVEL, SEL, event counts
//               and PWM duty.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotary_pwm_dimmer;

    localparam int c_CH  = 4;
    localparam int c_MAX = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rot_a = 1'b0;
    logic       rot_b = 1'b0;
    logic       rot_c = 1'b0;
    logic [3:0] led1, led4;
    logic [1:0] sel1, sel4;
    logic [3:0] level1, level4;
    logic       ev1, ev4;

    int n_pass  = 0;
    int n_total = 0;
    int ev_cnt1 = 0;
    int ev_cnt4 = 0;

    // Reference model: levels per channel for each step size, selection, events
    int lv1 [c_CH];
    int lv4 [c_CH];
    int msel   = 0;
    int exp_ev = 0;

    always #5 clk = ~clk;

    rotary_pwm_dimmer #(
        .PWM_BITS(4), .CHANNELS(c_CH), .STEP(1), .DEBOUNCE_CYCLES(4)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .ROT_A(rot_a), .ROT_B(rot_b), .ROT_CENTER(rot_c),
        .LED(led1), .SEL(sel1), .LEVEL(level1), .ROT_EVENT(ev1)
    );

    rotary_pwm_dimmer #(
        .PWM_BITS(4), .CHANNELS(c_CH), .STEP(4), .DEBOUNCE_CYCLES(4)
    ) u_dut4 (
        .CLK(clk), .RST(rst), .ROT_A(rot_a), .ROT_B(rot_b), .ROT_CENTER(rot_c),
        .LED(led4), .SEL(sel4), .LEVEL(level4), .ROT_EVENT(ev4)
    );

    // Count event pulses; a stuck-high pulse inflates the count
    always @(negedge clk) begin
        if (ev1 === 1'b1) ev_cnt1++;
        if (ev4 === 1'b1) ev_cnt4++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int hold_len();
        return int'($urandom_range(12, 8));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int sat_step(input int v, input bit right, input int step);
        int r;
        r = right ? v + step : v - step;
        if (r > c_MAX) r = c_MAX;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < c_CH; i++) begin
            lv1[i] = 0;
            lv4[i] = 0;
        end
        msel = 0;
    endtask

    task automatic detent(input bit right);
        if (!right) begin
            rot_b = 1'b1;
            tick(hold_len());
        end
        rot_a = 1'b1;
        tick(hold_len());
        rot_a = 1'b0;
        tick(hold_len());
        if (!right) begin
            rot_b = 1'b0;
            tick(hold_len());
        end
        lv1[msel] = sat_step(lv1[msel], right, 1);
        lv4[msel] = sat_step(lv4[msel], right, 4);
        exp_ev++;
    endtask

    task automatic press();
        rot_c = 1'b1;
        tick(hold_len());
        rot_c = 1'b0;
        tick(hold_len());
        msel = (msel + 1) % c_CH;
    endtask

    task automatic check_state(input string tag);
        check({tag, " level1"}, 32'(level1), 32'(lv1[msel]));
        check({tag, " level4"}, 32'(level4), 32'(lv4[msel]));
        check({tag, " sel1"},   32'(sel1),   32'(msel));
        check({tag, " sel4"},   32'(sel4),   32'(msel));
        check({tag, " events1"}, 32'(ev_cnt1), 32'(exp_ev));
        check({tag, " events4"}, 32'(ev_cnt4), 32'(exp_ev));
    endtask

    // Over any 15-cycle window, channel at level k is high exactly k cycles
    task automatic check_duty(input string tag);
        int c1 [c_CH];
        int c4 [c_CH];
        for (int i = 0; i < c_CH; i++) begin
            c1[i] = 0;
            c4[i] = 0;
        end
        repeat (c_MAX) begin
            tick(1);
            for (int i = 0; i < c_CH; i++) begin
                if (led1[i] === 1'b1) c1[i]++;
                if (led4[i] === 1'b1) c4[i]++;
            end
        end
        for (int i = 0; i < c_CH; i++) begin
            check($sformatf("%s duty1[%0d]", tag, i), 32'(c1[i]), 32'(lv1[i]));
            check($sformatf("%s duty4[%0d]", tag, i), 32'(c4[i]), 32'(lv4[i]));
        end
    endtask

    initial begin
        int led_or;
        int ev_before;
        bit dir;

        model_reset();

        // Power-on reset
        tick(3);
        check("por led1", 32'(led1), 0);
        check("por level1", 32'(level1), 0);
        check("por sel1", 32'(sel1), 0);
        check("por event1", 32'(ev1), 0);
        rst = 1'b0;
        tick(4);
        check_state("por idle");

        // Build some state, then reset in the middle of a detent
        repeat (3) begin
            detent(1'b1);
            check_state("pre-reset inc");
        end
        rot_a = 1'b1;
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        check("async rst led1", 32'(led1), 0);
        check("async rst led4", 32'(led4), 0);
        check("async rst sel1", 32'(sel1), 0);
        check("async rst level1", 32'(level1), 0);
        check("async rst level4", 32'(level4), 0);
        check("async rst event1", 32'(ev1), 0);
        rot_a = 1'b0;
        tick(2);
        rst = 1'b0;
        model_reset();
        led_or    = 0;
        ev_before = ev_cnt1;
        repeat (200) begin
            tick(1);
            led_or = led_or | int'(led1) | int'(led4);
        end
        check("idle led activity", 32'(led_or), 0);
        check("idle no events", 32'(ev_cnt1 - ev_before), 0);
        check_state("idle after reset");

        // Increment to saturation on channel 0
        for (int k = 1; k <= 20; k++) begin
            detent(1'b1);
            check_state($sformatf("inc %0d", k));
        end
        check_duty("saturated");

        // Decrement to level 5, check duty, then to floor
        repeat (10) detent(1'b0);
        check_state("dec to 5");
        check_duty("level 5");
        repeat (10) detent(1'b0);
        check_state("dec to 0");
        check_duty("floor");

        // Short glitches on A must not register
        rot_b = 1'b0;
        repeat (6) begin
            rot_a = 1'b1;
            tick(int'($urandom_range(3, 1)));
            rot_a = 1'b0;
            tick(8);
        end
        check_state("glitch reject");
        // Shortest accepted pulse: exactly the debounce time
        rot_a = 1'b1;
        tick(4);
        rot_a = 1'b0;
        tick(12);
        lv1[msel] = sat_step(lv1[msel], 1'b1, 1);
        lv4[msel] = sat_step(lv4[msel], 1'b1, 4);
        exp_ev++;
        check_state("clean edge");

        // Channel select wraps 1,2,3,0,1
        for (int k = 0; k < 5; k++) begin
            press();
            check($sformatf("press %0d sel", k), 32'(sel1), 32'((k + 1) % c_CH));
            check_state($sformatf("press %0d", k));
        end
        repeat (3) detent(1'b1);
        check_state("ch1 inc");
        check_duty("ch1 inc");

        // Move to channel 2, raise it, then detent and press together
        press();
        repeat (3) detent(1'b1);
        check_state("ch2 inc");
        rot_b = 1'b0;
        rot_a = 1'b1;
        tick(1);
        rot_c = 1'b1;
        tick(hold_len());
        rot_a = 1'b0;
        rot_c = 1'b0;
        tick(hold_len());
        lv1[msel] = sat_step(lv1[msel], 1'b1, 1);
        lv4[msel] = sat_step(lv4[msel], 1'b1, 4);
        exp_ev++;
        msel = (msel + 1) % c_CH;
        check_state("simultaneous");
        check_duty("simultaneous");

        // Random walk across channels
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(3, 0) == 0) press();
            dir = 1'($urandom_range(1, 0));
            detent(dir);
            check_state($sformatf("walk %0d", k));
        end
        check_duty("walk end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
